// File: rtl/excess3_to_bcd.sv
// excess3_to_bcd
//
// Collects a stream of excess-3 coded digits into a packed BCD word.
// Digits are shifted in at the least significant end, so the first digit
// received ends up most significant. A word closes after NDIG digits or on
// a digit flagged with in_last, whichever comes first. Partial words are
// right-justified with zeros above. The closed word is held until the
// consumer takes it, then the block returns to collecting.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_code    : excess-3 digit (legal 0011..1100)
//   in_valid   : in_code / in_last valid
//   in_last    : this digit closes the word early
//   in_ready   : block accepts a digit this cycle (collecting)
//   out_bcd    : packed BCD word, 4*NDIG bits
//   out_count  : digits in out_bcd (1..NDIG)
//   out_err    : at least one digit of the word had an illegal code
//   out_valid  : word outputs valid (holding)
//   out_ready  : consumer accepts the word

module excess3_to_bcd #(
    parameter int unsigned NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        in_code,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [4*NDIG-1:0] out_bcd,
    output logic [3:0]        out_count,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [0:0] {
        StCollect = 1'b0,
        StHold    = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [4*NDIG-1:0] asm_q, asm_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              accept;
    logic              code_legal;
    logic [3:0]        digit;
    logic              closing;

    localparam logic [3:0] LastIdx = 4'(NDIG - 1);

    // Decode: legal codes are 3..12, mapped to 0..9; anything else stores 0.
    always_comb begin
        code_legal = (in_code >= 4'd3) && (in_code <= 4'd12);
        digit      = code_legal ? (in_code - 4'd3) : 4'd0;
    end

    assign accept  = in_valid && (state_q == StCollect);
    // The NDIG-th digit closes regardless of in_last.
    assign closing = in_last || (cnt_q == LastIdx);

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    asm_d = {asm_q[4*NDIG-5:0], digit};
                    cnt_d = cnt_q + 4'd1;
                    err_d = err_q | ~code_legal;
                    if (closing) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                // Word leaves on the handshake; the next digit can only be
                // taken once back in collect, which gives the one-cycle bubble.
                if (out_ready) begin
                    asm_d   = '0;
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                    state_d = StCollect;
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCollect;
            asm_q   <= '0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // All outputs come straight from registers.
    assign in_ready  = (state_q == StCollect);
    assign out_valid = (state_q == StHold);
    assign out_bcd   = asm_q;
    assign out_count = cnt_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_excess3_to_bcd.sv
// Bench for excess3_to_bcd with NDIG=4: directed scenarios plus random words,
// checked against an arithmetic reference model.

module tb_excess3_to_bcd;

    localparam int unsigned NDIG = 4;

    logic              clk;
    logic              rst_n;
    logic [3:0]        in_code;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [4*NDIG-1:0] out_bcd;
    logic [3:0]        out_count;
    logic              out_err;
    logic              out_valid;
    logic              out_ready;

    int total = 0;
    int bad   = 0;

    // Word under test: codes in arrival order and how many.
    logic [3:0] wc [8];
    int         wn;

    excess3_to_bcd #(
        .NDIG(NDIG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_code  (in_code),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_bcd  (out_bcd),
        .out_count(out_count),
        .out_err  (out_err),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: value of a word as a BCD-packed number, digit = code-3 if legal.
    task automatic model(output logic [31:0] bcd, output logic [31:0] cnt,
                         output logic [31:0] err);
        int v;
        int d;
        v   = 0;
        err = 0;
        for (int i = 0; i < wn; i++) begin
            if (wc[i] >= 3 && wc[i] <= 12) begin
                d = int'(wc[i]) - 3;
            end else begin
                d   = 0;
                err = 1;
            end
            v = v * 16 + d;
        end
        bcd = v;
        cnt = wn;
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_digit(input logic [3:0] code, input logic last);
        int budget;
        in_code  = code;
        in_last  = last;
        in_valid = 1'b1;
        budget   = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input logic last_on_final);
        for (int i = 0; i < wn; i++) begin
            send_digit(wc[i], (i == wn - 1) ? last_on_final : 1'b0);
        end
    endtask

    // Wait for the word, compare to the model, then take it.
    task automatic deliver(input string tag, input int delay);
        logic [31:0] eb, ec, ee;
        int budget;
        budget = 0;
        while (!out_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        model(eb, ec, ee);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        end
        chk({tag, "_bcd"}, 32'(out_bcd), eb);
        chk({tag, "_count"}, 32'(out_count), ec);
        chk({tag, "_err"}, 32'(out_err), ee);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_done"}, 32'(out_valid), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_ov"}, 32'(out_valid), 32'd0);
        chk({tag, "_bcd"}, 32'(out_bcd), 32'd0);
        chk({tag, "_cnt"}, 32'(out_count), 32'd0);
        chk({tag, "_err"}, 32'(out_err), 32'd0);
    endtask

    initial begin
        logic [15:0] held;
        int          len;

        rst_n     = 1'b0;
        in_code   = 4'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Full word with the consumer always ready: valid for one cycle, one clock after.
        out_ready = 1'b1;
        wc = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
        wn = 4;
        send_word(1'b0);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_bcd", 32'(out_bcd), 32'h1234);
        chk("full_cnt", 32'(out_count), 32'd4);
        chk("full_err", 32'(out_err), 32'd0);
        chk("full_bubble", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("full_one_cycle", 32'(out_valid), 32'd0);
        chk("full_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // Early close.
        wc = '{4'hC, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        wn = 2;
        send_word(1'b1);
        chk("early_bcd_const", 32'(out_bcd), 32'h0090);
        deliver("early", 0);

        // Illegal code, then a clean word must have the error cleared.
        wc = '{4'h4, 4'hF, 4'h3, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0};
        wn = 4;
        send_word(1'b0);
        chk("illegal_bcd_const", 32'(out_bcd), 32'h1009);
        deliver("illegal", 0);
        wc = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
        send_word(1'b0);
        deliver("after_illegal", 0);

        // in_last on the last digit behaves as without it.
        wc = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
        send_word(1'b1);
        deliver("last_on_full", 0);

        // Backpressure with a digit waiting at the input.
        wc = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
        send_word(1'b0);
        held     = out_bcd;
        in_code  = 4'hB;
        in_last  = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_stable", 32'(out_bcd), 32'h2345);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        chk("bp_held", 32'(held), 32'h2345);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_released", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wc = '{4'hB, 4'h3, 4'h4, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};
        wn = 4;
        for (int i = 1; i < 4; i++) send_digit(wc[i], 1'b0);
        deliver("bp_next", 0);

        // Mid-word reset between edges.
        send_digit(4'h7, 1'b0);
        send_digit(4'h8, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        #1 rst_n = 1'b1;
        wc = '{4'h6, 4'h7, 4'h8, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0};
        wn = 4;
        send_word(1'b0);
        deliver("after_midreset", 0);

        // Reset while holding a word: that word must never appear.
        wc = '{4'hC, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        wn = 2;
        send_word(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("holdreset");
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("holdreset_no_word", 32'(out_valid), 32'd0);

        // Every code as a one-digit word.
        for (int c = 0; c < 16; c++) begin
            wc[0] = 4'(c);
            wn    = 1;
            send_word(1'b1);
            deliver($sformatf("code%0d", c), 0);
        end

        // Random words, lengths and consumer stalls.
        for (int w = 0; w < 40; w++) begin
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) wc[i] = 4'($urandom_range(0, 15));
            wn = len;
            send_word((len < 4) ? 1'b1 : 1'($urandom_range(0, 1)));
            deliver($sformatf("rand%0d", w), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
